cmd_write: RTL and testbench

Host-side transmitter for the SD CMD line. It serialises a 48-bit command frame (start bit, transmission bit, 6-bit index, 32-bit argument, CRC7, end bit), generating CRC7 on the fly, then enforces the Ncc idle gap before accepting the next command. It sits beside the response receiver on the same sd_clk_i domain and emits the pulse that arms that receiver. It also drives the CMD output enable.

---
 rtl/cmd_write.sv | 156 +++++++++++++++
 tb/tb_cmd_write.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cmd_write.sv
// SD CMD-line transmitter: serialises a 48-bit command frame with on-the-fly CRC7,
// then holds off for NccCycles idle clocks before accepting the next command.
module cmd_write #(
    parameter int unsigned NccCycles = 8
) (
    input  logic        sd_clk_i,
    input  logic        rst_ni,
    input  logic        start_tx_i,
    input  logic [5:0]  cmd_index_i,
    input  logic [31:0] cmd_argument_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        cmd_o,
    output logic        cmd_en_o,
    output logic        tx_done_o,
    output logic        start_listening_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_NCC = 2'd2
    } state_t;

    localparam logic [7:0] NccLast = 8'(NccCycles - 1);

    // One serial step of CRC7 with generator x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = crc[6] ^ bit_in;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    state_t      state_r, state_s;
    logic [5:0]  bit_cnt_r, bit_cnt_s;
    logic [7:0]  ncc_cnt_r, ncc_cnt_s;
    logic [38:0] shift_r, shift_s;
    logic [6:0]  crc_r, crc_s;
    logic        cmd_r, cmd_s;
    logic        cmd_en_r, cmd_en_s;
    logic        busy_r, busy_s;
    logic        ready_r, ready_s;
    logic        tx_done_r, tx_done_s;
    logic        listen_r, listen_s;

    // Next-state and next-output logic; bit_cnt_r is the index of the bit currently on cmd_o.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        ncc_cnt_s = ncc_cnt_r;
        shift_s   = shift_r;
        crc_s     = crc_r;
        cmd_s     = 1'b1;
        cmd_en_s  = 1'b0;
        busy_s    = 1'b0;
        ready_s   = 1'b0;
        tx_done_s = 1'b0;
        listen_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_tx_i) begin
                    // Start bit goes out now; shift_r keeps frame bits 46..8.
                    state_s   = SEND;
                    bit_cnt_s = 6'd0;
                    shift_s   = {1'b1, cmd_index_i, cmd_argument_i};
                    crc_s     = crc7_step(7'h00, 1'b0);
                    cmd_s     = 1'b0;
                    cmd_en_s  = 1'b1;
                    busy_s    = 1'b1;
                end else begin
                    ready_s = 1'b1;
                end
            end
            SEND: begin
                cmd_en_s  = 1'b1;
                busy_s    = 1'b1;
                bit_cnt_s = bit_cnt_r + 6'd1;
                if (bit_cnt_r == 6'd47) begin
                    state_s   = WAIT_NCC;
                    cmd_en_s  = 1'b0;
                    busy_s    = 1'b0;
                    tx_done_s = 1'b1;
                    bit_cnt_s = 6'd0;
                    ncc_cnt_s = 8'd0;
                    crc_s     = 7'h00;
                end else if (bit_cnt_r < 6'd39) begin
                    cmd_s   = shift_r[38];
                    shift_s = {shift_r[37:0], 1'b0};
                    crc_s   = crc7_step(crc_r, shift_r[38]);
                end else if (bit_cnt_r < 6'd46) begin
                    // CRC already covers bit 8, so its MSB follows with no gap.
                    cmd_s = crc_r[6];
                    crc_s = {crc_r[5:0], 1'b0};
                end else begin
                    cmd_s = 1'b1;
                end
            end
            WAIT_NCC: begin
                ncc_cnt_s = ncc_cnt_r + 8'd1;
                if (ncc_cnt_r == 8'd0) begin
                    listen_s = 1'b1;
                end else begin
                    listen_s = 1'b0;
                end
                if (ncc_cnt_r == NccLast) begin
                    state_s   = IDLE;
                    ready_s   = 1'b1;
                    ncc_cnt_s = 8'd0;
                end else begin
                    ready_s = 1'b0;
                end
            end
            default: begin
                state_s = IDLE;
                ready_s = 1'b1;
            end
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge sd_clk_i) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            bit_cnt_r <= 6'd0;
            ncc_cnt_r <= 8'd0;
            shift_r   <= 39'd0;
            crc_r     <= 7'h00;
            cmd_r     <= 1'b1;
            cmd_en_r  <= 1'b0;
            busy_r    <= 1'b0;
            ready_r   <= 1'b1;
            tx_done_r <= 1'b0;
            listen_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            ncc_cnt_r <= ncc_cnt_s;
            shift_r   <= shift_s;
            crc_r     <= crc_s;
            cmd_r     <= cmd_s;
            cmd_en_r  <= cmd_en_s;
            busy_r    <= busy_s;
            ready_r   <= ready_s;
            tx_done_r <= tx_done_s;
            listen_r  <= listen_s;
        end
    end

    assign ready_o           = ready_r;
    assign busy_o            = busy_r;
    assign cmd_o             = cmd_r;
    assign cmd_en_o          = cmd_en_r;
    assign tx_done_o         = tx_done_r;
    assign start_listening_o = listen_r;

endmodule

// File: tb/tb_cmd_write.sv
// Randomised bench for cmd_write: a per-cycle timeline model derived from the accept edge
// predicts every output, and a negedge compare process checks the DUT against it.
module tb_cmd_write;

    localparam int NCC  = 8;
    localparam int NONE = -100000;

    logic        clk;
    logic        rst_n;
    logic        start_tx;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        ready, busy, cmd, cmd_en, tx_done, listen;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int k_m    = NONE;
    logic [47:0] frame_m = 48'd0;
    logic chk_en = 1'b0;

    cmd_write #(.NccCycles(NCC)) dut (
        .sd_clk_i          (clk),
        .rst_ni            (rst_n),
        .start_tx_i        (start_tx),
        .cmd_index_i       (idx),
        .cmd_argument_i    (arg),
        .ready_o           (ready),
        .busy_o            (busy),
        .cmd_o             (cmd),
        .cmd_en_o          (cmd_en),
        .tx_done_o         (tx_done),
        .start_listening_o (listen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame built from its definition; CRC7 as polynomial long division by 0x89.
    function automatic logic [47:0] build_frame(input logic [5:0] i, input logic [31:0] a);
        logic [46:0] r;
        r = {2'b01, i, a, 7'h00};
        for (int b = 46; b >= 7; b--) begin
            if (r[b]) r[b -: 8] = r[b -: 8] ^ 8'h89;
        end
        return {2'b01, i, a, r[6:0], 1'b1};
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, edge_n, act, exp);
        end
    endtask

    function automatic bit model_ready(input int c);
        int d;
        d = c - k_m;
        return !(d >= 1 && d <= 48 + NCC);
    endfunction

    // Model: note the accept edge and the frame sampled there; reset drops any frame.
    always @(posedge clk) begin
        if (!rst_n) begin
            k_m = NONE;
        end else if (model_ready(edge_n) && start_tx) begin
            k_m     = edge_n;
            frame_m = build_frame(idx, arg);
        end
        edge_n = edge_n + 1;
    end

    // Compare every output against the timeline offset from the last accept.
    always @(negedge clk) begin
        if (chk_en) begin
            int d;
            bit en_e;
            d    = edge_n - k_m;
            en_e = (d >= 1 && d <= 48);
            chk("cmd_en",  {47'd0, cmd_en},  {47'd0, en_e});
            chk("busy",    {47'd0, busy},    {47'd0, en_e});
            chk("cmd",     {47'd0, cmd},     {47'd0, (en_e ? frame_m[48 - d] : 1'b1)});
            chk("tx_done", {47'd0, tx_done}, {47'd0, (d == 49)});
            chk("listen",  {47'd0, listen},  {47'd0, (d == 50)});
            chk("ready",   {47'd0, ready},   {47'd0, model_ready(edge_n)});
        end
    end

    task automatic send(input logic [5:0] i, input logic [31:0] a);
        start_tx = 1'b1;
        idx      = i;
        arg      = a;
        @(negedge clk);
        start_tx = 1'b0;
        idx      = 6'($urandom);
        arg      = $urandom;
    endtask

    initial begin
        rst_n    = 1'b0;
        start_tx = 1'b0;
        idx      = 6'd0;
        arg      = 32'd0;

        chk("model_cmd0",  build_frame(6'd0,  32'h0),     48'h400000000095);
        chk("model_cmd17", build_frame(6'd17, 32'h0),     48'h510000000055);
        chk("model_cmd8",  build_frame(6'd8,  32'h1AA),   48'h48000001AA87);

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        repeat (2) @(negedge clk);

        send(6'd0, 32'h0);
        repeat (65) @(negedge clk);
        send(6'd17, 32'h0);
        repeat (65) @(negedge clk);
        send(6'd8, 32'h000001AA);
        repeat (65) @(negedge clk);

        // Held request: back-to-back frames, inputs churn every cycle.
        start_tx = 1'b1;
        for (int n = 0; n < 150; n++) begin
            idx = 6'($urandom);
            arg = $urandom;
            @(negedge clk);
        end
        start_tx = 1'b0;
        repeat (65) @(negedge clk);

        // Request during SEND must be ignored.
        send(6'd55, 32'hDEADBEEF);
        repeat (9) @(negedge clk);
        send(6'd3, 32'h12345678);
        repeat (70) @(negedge clk);

        // Reset for one edge while bit 20 is on the line.
        send(6'd41, 32'hA5A5_5A5A);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send(6'd8, 32'h000001AA);
        repeat (70) @(negedge clk);

        for (int n = 0; n < 3000; n++) begin
            start_tx = ($urandom_range(0, 9) == 0);
            idx      = 6'($urandom);
            arg      = $urandom;
            rst_n    = ($urandom_range(0, 399) != 0);
            @(negedge clk);
        end
        start_tx = 1'b0;
        rst_n    = 1'b1;
        repeat (70) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
